// File: rtl/tmr32_pkg.sv
// -----------------------------------------------------------------------------
// tmr32_pkg
// Shared definitions for the timer capture-record buffer.
//   state_t   : event-handshake FSM states (IDLE samples events, CLR returns
//               the clear pulse to the timer)
//   DROPS_W   : width of the dropped-event counter
//   DROPS_MAX : saturation value of the dropped-event counter
// -----------------------------------------------------------------------------
package tmr32_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } state_t;

  localparam int                 DROPS_W   = 8;
  localparam logic [DROPS_W-1:0] DROPS_MAX = 8'hFF;

endpackage

// File: rtl/cap_fifo.sv
// -----------------------------------------------------------------------------
// cap_fifo
// Synchronous first-word-fall-through FIFO, DEPTH x WIDTH.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/level only)
//   push       : write request for wdata
//   pop        : remove head entry; ignored while empty
//   flush      : drop all entries; overrides same-cycle push and pop
//   wdata      : data to write
//   rdata      : head entry, 0 while empty
//   empty/full : occupancy flags
//   level      : entries held, 0..DEPTH
//   push_ok    : push request accepted this cycle (before flush override)
// -----------------------------------------------------------------------------
module cap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level,
  output logic             push_ok
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tmr32_capture_fifo.sv
// -----------------------------------------------------------------------------
// tmr32_capture_fifo
// Capture-record buffer downstream of the 32-bit timer input-capture path.
// Each sampled timer event pushes CAPTURE into a FWFT FIFO and returns a
// one-cycle clear pulse to the timer's sticky event flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   EN         : block enable (event handling only; FIFO port always live)
//   CAPTURE    : timer capture register
//   EEVF       : timer sticky external-event flag
//   EEVF_CLR   : registered one-cycle clear pulse back to the timer
//   RD         : pop head entry
//   FLUSH      : empty the FIFO
//   RDATA      : head entry, 0 when empty
//   EMPTY/FULL : occupancy flags
//   LEVEL      : entries held
//   THRESH     : level IRQ threshold, 0 disables the level term
//   OVR        : sticky, an event was dropped while full
//   OVR_CLR    : clears OVR and DROPS
//   DROPS      : saturating dropped-event count
//   IRQ        : level-threshold or overrun interrupt
// -----------------------------------------------------------------------------
module tmr32_capture_fifo
  import tmr32_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               EN,
  input  logic [WIDTH-1:0]   CAPTURE,
  input  logic               EEVF,
  output logic               EEVF_CLR,
  input  logic               RD,
  input  logic               FLUSH,
  output logic [WIDTH-1:0]   RDATA,
  output logic               EMPTY,
  output logic               FULL,
  output logic [LW-1:0]      LEVEL,
  input  logic [LW-1:0]      THRESH,
  output logic               OVR,
  input  logic               OVR_CLR,
  output logic [DROPS_W-1:0] DROPS,
  output logic               IRQ
);

  state_t state;
  logic   cap_evt;
  logic   push_ok;
  logic   drop;

  function automatic logic [DROPS_W-1:0] sat_inc(input logic [DROPS_W-1:0] v);
    return (v == DROPS_MAX) ? v : v + 1'b1;
  endfunction

  // Events are only sampled in IDLE; the flag is still high during CLR.
  assign cap_evt = EN && (state == IDLE) && EEVF;

  // A flushed event is consumed, not dropped.
  assign drop = cap_evt && !FLUSH && !push_ok;

  cap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (cap_evt),
    .pop     (RD),
    .flush   (FLUSH),
    .wdata   (CAPTURE),
    .rdata   (RDATA),
    .empty   (EMPTY),
    .full    (FULL),
    .level   (LEVEL),
    .push_ok (push_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      EEVF_CLR <= 1'b0;
    end else if (!EN) begin
      state    <= IDLE;
      EEVF_CLR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (EEVF) begin
            state    <= CLR;
            EEVF_CLR <= 1'b1;
          end else begin
            EEVF_CLR <= 1'b0;
          end
        end
        CLR: begin
          state    <= IDLE;
          EEVF_CLR <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          EEVF_CLR <= 1'b0;
        end
      endcase
    end
  end

  // A drop in the same cycle as OVR_CLR wins and restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OVR   <= 1'b0;
      DROPS <= '0;
    end else if (drop) begin
      OVR   <= 1'b1;
      DROPS <= OVR_CLR ? DROPS_W'(1) : sat_inc(DROPS);
    end else if (OVR_CLR) begin
      OVR   <= 1'b0;
      DROPS <= '0;
    end
  end

  assign IRQ = ((THRESH != '0) && (LEVEL >= THRESH)) || OVR;

endmodule

// File: tb/tb_tmr32_capture_fifo.sv
// -----------------------------------------------------------------------------
// tb_tmr32_capture_fifo
// Directed scenarios followed by randomized traffic. A monitor keeps a queue
// model of the buffer contents, overrun flag and drop count, and compares the
// DUT outputs against it one time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_tmr32_capture_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int LW    = 4;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             EN      = 1'b0;
  logic [WIDTH-1:0] CAPTURE = '0;
  logic             EEVF    = 1'b0;
  logic             RD      = 1'b0;
  logic             FLUSH   = 1'b0;
  logic [LW-1:0]    THRESH  = '0;
  logic             OVR_CLR = 1'b0;

  logic             EEVF_CLR;
  logic [WIDTH-1:0] RDATA;
  logic             EMPTY;
  logic             FULL;
  logic [LW-1:0]    LEVEL;
  logic             OVR;
  logic [7:0]       DROPS;
  logic             IRQ;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr32_capture_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .LW    (LW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .EN       (EN),
    .CAPTURE  (CAPTURE),
    .EEVF     (EEVF),
    .EEVF_CLR (EEVF_CLR),
    .RD       (RD),
    .FLUSH    (FLUSH),
    .RDATA    (RDATA),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .LEVEL    (LEVEL),
    .THRESH   (THRESH),
    .OVR      (OVR),
    .OVR_CLR  (OVR_CLR),
    .DROPS    (DROPS),
    .IRQ      (IRQ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and monitor
  // ---------------------------------------------------------------------------
  logic [31:0] mq[$];
  logic        m_ovr   = 1'b0;
  int          m_drops = 0;
  logic        m_clr   = 1'b0;

  initial begin : monitor
    logic ev;
    logic acc;
    logic [31:0] exp_rdata;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_ovr   = 1'b0;
        m_drops = 0;
        m_clr   = 1'b0;
      end else begin
        ev  = EN && !m_clr && EEVF;
        acc = 1'b0;
        if (FLUSH) begin
          mq.delete();
        end else begin
          if (RD && mq.size() > 0) void'(mq.pop_front());
          if (ev && mq.size() < DEPTH) begin
            mq.push_back(CAPTURE);
            acc = 1'b1;
          end
        end
        if (ev && !FLUSH && !acc) begin
          m_ovr   = 1'b1;
          m_drops = OVR_CLR ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        end else if (OVR_CLR) begin
          m_ovr   = 1'b0;
          m_drops = 0;
        end
        m_clr = ev;
      end
      #1;
      exp_rdata = (mq.size() > 0) ? mq[0] : 32'h0;
      chk("eevf_clr", 32'(EEVF_CLR), 32'(m_clr));
      chk("rdata",    RDATA, exp_rdata);
      chk("empty",    32'(EMPTY), 32'(mq.size() == 0));
      chk("full",     32'(FULL),  32'(mq.size() == DEPTH));
      chk("level",    32'(LEVEL), mq.size());
      chk("ovr",      32'(OVR),   32'(m_ovr));
      chk("drops",    32'(DROPS), m_drops);
      chk("irq",      32'(IRQ),   32'(((THRESH != 0) && (mq.size() >= THRESH)) || m_ovr));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle event; returns at the falling edge of the clear-pulse cycle.
  task automatic event1(input logic [31:0] v, input logic rd = 1'b0, input logic fl = 1'b0);
    @(negedge clk);
    CAPTURE = v;
    EEVF    = 1'b1;
    RD      = rd;
    FLUSH   = fl;
    @(negedge clk);
    EEVF  = 1'b0;
    RD    = 1'b0;
    FLUSH = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    RD = 1'b1;
    @(negedge clk);
    RD = 1'b0;
  endtask

  initial begin : stimulus
    int          n;
    logic [31:0] last;
    int          gap;

    cyc(3);
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_irq",   32'(IRQ),   32'd0);
    rst_n = 1'b1;
    EN    = 1'b1;
    cyc(2);

    // Three spaced events, then drain in order.
    event1(32'h100); cyc(3);
    event1(32'h200); cyc(3);
    event1(32'h300); cyc(3);
    chk("three_level", 32'(LEVEL), 32'd3);
    chk("three_head",  RDATA, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("drain_data", RDATA, 32'((i + 1) * 32'h100));
      pop1();
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);
    chk("drain_rdata", RDATA, 32'h0);

    // EEVF held for two cycles gives a single push and a single clear pulse.
    @(negedge clk);
    CAPTURE = 32'h55;
    EEVF    = 1'b1;
    n       = 0;
    @(negedge clk);
    chk("clr_cycle_level", 32'(LEVEL), 32'd1);
    chk("clr_cycle_pulse", 32'(EEVF_CLR), 32'd1);
    n += int'(EEVF_CLR);
    @(negedge clk);
    EEVF = 1'b0;
    n += int'(EEVF_CLR);
    repeat (4) begin
      @(negedge clk);
      n += int'(EEVF_CLR);
    end
    chk("clr_pulse_count", n, 32'd1);
    chk("held_one_push",   32'(LEVEL), 32'd1);
    pop1();

    // Fill, then overflow by three.
    for (int i = 0; i < DEPTH; i++) begin
      event1(32'h10 + i); cyc(1);
    end
    for (int i = 0; i < 3; i++) begin
      event1(32'hDEAD); cyc(1);
    end
    chk("ovf_full",  32'(FULL),  32'd1);
    chk("ovf_level", 32'(LEVEL), 32'd8);
    chk("ovf_ovr",   32'(OVR),   32'd1);
    chk("ovf_drops", 32'(DROPS), 32'd3);
    chk("ovf_irq",   32'(IRQ),   32'd1);
    @(negedge clk); OVR_CLR = 1'b1;
    @(negedge clk); OVR_CLR = 1'b0;
    chk("ovrclr_ovr",   32'(OVR),   32'd0);
    chk("ovrclr_drops", 32'(DROPS), 32'd0);

    // Full with a coincident read: the event is kept.
    event1(32'hABC, 1'b1);
    cyc(1);
    chk("coinc_level", 32'(LEVEL), 32'd8);
    chk("coinc_ovr",   32'(OVR),   32'd0);
    chk("coinc_head",  RDATA, 32'h11);
    last = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      last = RDATA;
      pop1();
    end
    chk("coinc_last",  last, 32'hABC);
    chk("coinc_empty", 32'(EMPTY), 32'd1);

    // Level threshold interrupt.
    THRESH = 4'd4;
    for (int i = 0; i < 3; i++) begin
      event1(32'h40 + i); cyc(1);
    end
    chk("thr_below", 32'(IRQ), 32'd0);
    event1(32'h43); cyc(1);
    chk("thr_at", 32'(IRQ), 32'd1);
    pop1();
    chk("thr_after_rd", 32'(IRQ), 32'd0);
    THRESH = 4'd0;
    for (int i = 0; i < 5; i++) begin
      event1(32'h50 + i); cyc(1);
    end
    chk("thr0_level", 32'(LEVEL), 32'd8);
    chk("thr0_irq",   32'(IRQ),   32'd0);

    // Flush with coincident event and read at level 5, then reset mid-clear.
    for (int i = 0; i < 3; i++) pop1();
    chk("pre_flush_level", 32'(LEVEL), 32'd5);
    event1(32'h777, 1'b1, 1'b1);
    chk("flush_level", 32'(LEVEL),    32'd0);
    chk("flush_clr",   32'(EEVF_CLR), 32'd1);
    chk("flush_ovr",   32'(OVR),      32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_clr",   32'(EEVF_CLR), 32'd0);
    chk("arst_rdata", RDATA,         32'h0);
    chk("arst_empty", 32'(EMPTY),    32'd1);
    chk("arst_full",  32'(FULL),     32'd0);
    chk("arst_level", 32'(LEVEL),    32'd0);
    chk("arst_ovr",   32'(OVR),      32'd0);
    chk("arst_drops", 32'(DROPS),    32'd0);
    chk("arst_irq",   32'(IRQ),      32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Randomized traffic with a timer stub that honours the clear pulse.
    gap = 3;
    for (int seg = 0; seg < 2; seg++) begin
      repeat (500) begin
        @(negedge clk);
        RD      = ($urandom_range(99) < ((seg == 0) ? 15 : 50));
        FLUSH   = ($urandom_range(199) == 0);
        OVR_CLR = ($urandom_range(49) == 0);
        if ($urandom_range(63) == 0) THRESH = LW'($urandom_range(DEPTH));
        if ($urandom_range(99) < 3) EN = ~EN;
        if (EEVF_CLR) begin
          EEVF = 1'b0;
        end else if (!EEVF && gap >= 3 && $urandom_range(99) < 60) begin
          EEVF    = 1'b1;
          CAPTURE = $urandom;
          gap     = 0;
        end
        gap++;
      end
    end
    @(negedge clk);
    RD = 1'b0; FLUSH = 1'b0; OVR_CLR = 1'b0; EEVF = 1'b0; EN = 1'b1;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr32_capture_fifo.md
# tmr32_capture_fifo

Capture-record buffer sitting directly downstream of the 32-bit timer's input-capture path. Watches the timer's sticky external-event flag, pushes the timer's capture register into a FIFO on every event, and returns the clear pulse to the timer so software never services each edge individually. The CPU drains records through a first-word-fall-through read port, with a level-threshold interrupt, an overrun flag and a drop counter.

## Interface
- DEPTH, 8, FIFO entries; power of two, ≥2
- WIDTH, 32, capture word width
- LW, $clog2(DEPTH)+1, level/threshold width (derived)

Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  async active-low reset
- EN  in  1  block enable
- CAPTURE  in  WIDTH  timer capture register
- EEVF  in  1  timer sticky external-event flag
- EEVF_CLR  out  1  registered one-cycle clear pulse to timer
- RD  in  1  pop head entry (pulse)
- FLUSH  in  1  empty FIFO
- RDATA  out  WIDTH  head entry; 0 when empty
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO full
- LEVEL  out  LW  entries held, 0..DEPTH
- THRESH  in  LW  IRQ level threshold; 0 disables level IRQ
- OVR  out  1  sticky: event dropped while full
- OVR_CLR  in  1  clears OVR and DROPS
- DROPS  out  8  saturating dropped-event count
- IRQ  out  1  (THRESH≠0 & LEVEL≥THRESH) | OVR

## Operation
- FSM states: IDLE, CLR. Reset → IDLE.
- IDLE, EN=1, EEVF=1: capture event. Push CAPTURE if not FULL, or if FULL with RD the same cycle (pop and push together, LEVEL unchanged). Otherwise drop: OVR←1, DROPS←min(DROPS+1,255). Either way → CLR.
- CLR: EEVF_CLR=1 for exactly this cycle; no event sampling; → IDLE.
- EN=0: FSM forced to IDLE, EEVF_CLR=0, no pushes; FIFO contents, RD, FLUSH still operate.
- RD while EMPTY: ignored. RD with no push: LEVEL−1.
- FLUSH: pointers and LEVEL to 0; overrides same-cycle push and RD (event counts as consumed, FSM still → CLR, not a drop). OVR/DROPS unaffected.
- OVR_CLR: clears OVR and DROPS; loses to a same-cycle drop (OVR stays 1, DROPS=1).
- Pointers wrap modulo DEPTH; LEVEL never exceeds DEPTH, never underflows.

## Timing
- Reset values: EEVF_CLR=0, RDATA=0, EMPTY=1, FULL=0, LEVEL=0, OVR=0, DROPS=0, IRQ=0.
- Event at timer edge N: EEVF and CAPTURE valid in cycle N+1; push occurs at end of N+1; EMPTY falls, LEVEL/RDATA update in N+2; EEVF_CLR high during N+2; timer EEVF low from N+3.
- RDATA is first-word-fall-through: valid combinationally whenever EMPTY=0; after RD the next entry appears the following cycle.
- Timer gives clear priority over set, so a capture event landing in the EEVF_CLR cycle is lost by the timer. Minimum supported event spacing: 3 clk. Documented limitation; not detected.
- IRQ is combinational from registered state; no extra latency.

## Structure
- Shared package `tmr32_pkg`: FSM state enum (IDLE, CLR), DROPS width constant, DROPS saturation value.
- One sub-module: `cap_fifo` — synchronous FWFT FIFO (DEPTH×WIDTH, push/pop/flush, level, full/empty). FSM, drop logic and IRQ live in the top.

## Test plan
- Reset then EN=1, EEVF pulses with CAPTURE=0x100, 0x200, 0x300 spaced 5 clk → LEVEL=3, RDATA=0x100; three RDs yield 0x100, 0x200, 0x300, EMPTY=1, RDATA=0.
- Single event → exactly one EEVF_CLR pulse one cycle after push; EEVF held high by stub for 2 cycles → still one push.
- DEPTH=8 fill, then 3 more events → FULL=1, LEVEL=8, OVR=1, DROPS=3, IRQ=1; OVR_CLR → OVR=0, DROPS=0.
- FULL with RD coincident with event (CAPTURE=0xABC) → LEVEL stays 8, OVR=0, 0xABC is last entry read.
- THRESH=4: 3 events → IRQ=0; 4th → IRQ=1; one RD → IRQ=0. THRESH=0 with 8 entries → IRQ=0.
- FLUSH coincident with event and RD at LEVEL=5 → LEVEL=0, EEVF_CLR pulses, OVR=0; rst_n asserted mid-CLR → all outputs at reset values immediately.
